// File: rtl/rtc_bus_cycle.sv
// rtl/rtc_bus_cycle.sv - multiplexed-bus transaction generator for the RTC chip
//
// Purpose:
//   Runs one complete RTC bus transaction for each accepted request. The
//   address phase always strobes WR to latch the address. The data phase
//   then either strobes WR with the write byte, or strobes RD and captures
//   the byte the chip drives. Every non-idle state lasts exactly T_PHASE
//   cycles. After the GAP state there is a single done cycle spent in IDLE.
//
// Parameters:
//   T_PHASE   cycles per non-idle state, legal range 2..255
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous active-high reset
//   start_wr  write request, sampled in IDLE only (wins over start_rd)
//   start_rd  read request, sampled in IDLE only
//   addr      register address byte, latched at accept
//   wr_data   write data byte, latched at accept
//   ad_in     AD bus pad input
//   ad_out    AD bus output value
//   ad_oe     1 = drive AD bus, 0 = tri-state
//   cs_n      chip select, active-low
//   ad_n      0 = address phase, 1 = data phase
//   wr_n      write strobe, active-low
//   rd_n      read strobe, active-low
//   rd_data   byte captured by the last completed read
//   busy      high from accept until the done cycle (exclusive)
//   done      one-cycle pulse at transaction end

module rtc_bus_cycle #(
  parameter int T_PHASE = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_wr,
  input  logic       start_rd,
  input  logic [7:0] addr,
  input  logic [7:0] wr_data,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       ad_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_A_SET = 3'd1;
  localparam logic [2:0] S_A_STB = 3'd2;
  localparam logic [2:0] S_A_HLD = 3'd3;
  localparam logic [2:0] S_D_SET = 3'd4;
  localparam logic [2:0] S_D_STB = 3'd5;
  localparam logic [2:0] S_D_HLD = 3'd6;
  localparam logic [2:0] S_GAP   = 3'd7;

  localparam logic [7:0] C_LOAD = 8'(T_PHASE - 1);

  logic [2:0] r_state;
  logic [7:0] r_cnt;
  logic [7:0] r_addr;
  logic [7:0] r_wdata;
  logic       r_is_wr;

  logic [7:0] r_ad_out;
  logic       r_ad_oe;
  logic       r_cs_n;
  logic       r_ad_n;
  logic       r_wr_n;
  logic       r_rd_n;
  logic [7:0] r_rd_data;
  logic       r_busy;
  logic       r_done;

  logic [2:0] w_next;
  logic       w_accept;
  logic       w_phase_end;
  logic       w_op_wr;
  logic [7:0] w_addr_sel;
  logic [7:0] w_wdata_sel;

  assign w_accept    = (r_state == S_IDLE) && (start_wr || start_rd);
  assign w_phase_end = (r_state != S_IDLE) && (r_cnt == 8'd0);

  // The outputs are registered from the next state. On the accept edge the
  // latched registers are not loaded yet, so the request inputs are used
  // directly for that one edge.
  assign w_op_wr     = w_accept ? start_wr : r_is_wr;
  assign w_addr_sel  = w_accept ? addr     : r_addr;
  assign w_wdata_sel = w_accept ? wr_data  : r_wdata;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)    w_next = S_A_SET;
      S_A_SET: if (w_phase_end) w_next = S_A_STB;
      S_A_STB: if (w_phase_end) w_next = S_A_HLD;
      S_A_HLD: if (w_phase_end) w_next = S_D_SET;
      S_D_SET: if (w_phase_end) w_next = S_D_STB;
      S_D_STB: if (w_phase_end) w_next = S_D_HLD;
      S_D_HLD: if (w_phase_end) w_next = S_GAP;
      S_GAP:   if (w_phase_end) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State, phase counter and request latch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_addr  <= 8'h00;
      r_wdata <= 8'h00;
      r_is_wr <= 1'b0;
    end else begin
      r_state <= w_next;
      // Every transition enters a new state, so reload on any state change.
      if (w_next != r_state) begin
        r_cnt <= C_LOAD;
      end else if (r_cnt != 8'd0) begin
        r_cnt <= r_cnt - 8'd1;
      end
      if (w_accept) begin
        r_addr  <= addr;
        r_wdata <= wr_data;
        r_is_wr <= start_wr;
      end
    end
  end

  // Registered pin outputs decoded from the state being entered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cs_n   <= 1'b1;
      r_ad_n   <= 1'b1;
      r_wr_n   <= 1'b1;
      r_rd_n   <= 1'b1;
      r_ad_oe  <= 1'b0;
      r_ad_out <= 8'h00;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= (r_state == S_GAP) && (w_next == S_IDLE);
      r_busy <= (w_next != S_IDLE);
      case (w_next)
        S_A_SET, S_A_HLD: begin
          r_cs_n   <= 1'b0;
          r_ad_n   <= 1'b0;
          r_wr_n   <= 1'b1;
          r_rd_n   <= 1'b1;
          r_ad_oe  <= 1'b1;
          r_ad_out <= w_addr_sel;
        end
        S_A_STB: begin
          r_cs_n   <= 1'b0;
          r_ad_n   <= 1'b0;
          r_wr_n   <= 1'b0;
          r_rd_n   <= 1'b1;
          r_ad_oe  <= 1'b1;
          r_ad_out <= w_addr_sel;
        end
        S_D_SET, S_D_HLD, S_D_STB: begin
          r_cs_n  <= 1'b0;
          r_ad_n  <= 1'b1;
          r_ad_oe <= w_op_wr;
          // On a read, ad_out keeps the address; it is not driven anyway.
          if (w_op_wr) begin
            r_ad_out <= w_wdata_sel;
          end
          r_wr_n <= !((w_next == S_D_STB) && w_op_wr);
          r_rd_n <= !((w_next == S_D_STB) && !w_op_wr);
        end
        default: begin
          // IDLE and GAP: bus released, ad_out holds its last value
          r_cs_n  <= 1'b1;
          r_ad_n  <= 1'b1;
          r_wr_n  <= 1'b1;
          r_rd_n  <= 1'b1;
          r_ad_oe <= 1'b0;
        end
      endcase
    end
  end

  // Capture on the edge that ends the last D_STB cycle of a read, while
  // rd_n is still low at the pins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_data <= 8'h00;
    end else if ((r_state == S_D_STB) && w_phase_end && !r_is_wr) begin
      r_rd_data <= ad_in;
    end
  end

  assign ad_out  = r_ad_out;
  assign ad_oe   = r_ad_oe;
  assign cs_n    = r_cs_n;
  assign ad_n    = r_ad_n;
  assign wr_n    = r_wr_n;
  assign rd_n    = r_rd_n;
  assign rd_data = r_rd_data;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_rtc_bus_cycle.sv
// tb/tb_rtc_bus_cycle.sv - self-checking bench for rtc_bus_cycle with a read-data scoreboard

module tb_rtc_bus_cycle;

  localparam int T   = 4;
  localparam int LEN = 7 * T + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_wr;
  logic       start_rd;
  logic [7:0] addr;
  logic [7:0] wr_data;
  logic [7:0] ad_in;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic       cs_n;
  logic       ad_n;
  logic       wr_n;
  logic       rd_n;
  logic [7:0] rd_data;
  logic       busy;
  logic       done;

  int n_pass  = 0;
  int n_total = 0;
  int viol    = 0;
  bit mon_en  = 1'b0;

  logic [7:0] m_rd = 8'h00;
  logic [7:0] sb_q[$];

  logic tr_cs   [0:63];
  logic tr_adn  [0:63];
  logic tr_wr   [0:63];
  logic tr_rd   [0:63];
  logic tr_oe   [0:63];
  logic tr_busy [0:63];
  logic tr_done [0:63];
  logic [7:0] tr_out [0:63];

  rtc_bus_cycle #(.T_PHASE(T)) dut (
    .clk      (clk),
    .reset    (reset),
    .start_wr (start_wr),
    .start_rd (start_rd),
    .addr     (addr),
    .wr_data  (wr_data),
    .ad_in    (ad_in),
    .ad_out   (ad_out),
    .ad_oe    (ad_oe),
    .cs_n     (cs_n),
    .ad_n     (ad_n),
    .wr_n     (wr_n),
    .rd_n     (rd_n),
    .rd_data  (rd_data),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Bus-protocol invariants sampled every cycle
  logic       p_valid = 1'b0;
  logic       p_oe;
  logic       p_wr;
  logic       p_rd;
  logic [7:0] p_out;
  always @(negedge clk) begin
    int bad;
    bad = 0;
    if (mon_en) begin
      if (!wr_n && !rd_n) bad = bad + 1;
      if (cs_n && (!wr_n || !rd_n)) bad = bad + 1;
      if (p_valid && ((ad_oe !== p_oe) || (ad_out !== p_out)) &&
          (!wr_n || !rd_n || !p_wr || !p_rd)) bad = bad + 1;
    end
    viol    <= viol + bad;
    p_valid <= mon_en;
    p_oe    <= ad_oe;
    p_out   <= ad_out;
    p_wr    <= wr_n;
    p_rd    <= rd_n;
  end

  // One transaction: drives the request, records a trace for cycles 1..LEN
  // and checks every cycle against the expected pin pattern. If no_wait is
  // set, the request is issued in the current (done) cycle.
  task automatic drive_txn(input bit no_wait, input logic wr, input logic rd,
                           input logic [7:0] a, input logic [7:0] d,
                           input logic [7:0] rb, input int pulse_c);
    int errs;
    int ph;
    int bad_c;
    logic [6:0] got;
    logic [6:0] exp;
    logic [6:0] bad_got;
    logic [6:0] bad_exp;
    logic [7:0] exp_rd;
    errs    = 0;
    bad_c   = 0;
    bad_got = '0;
    bad_exp = '0;
    if (!no_wait) @(negedge clk);
    start_wr = wr;
    start_rd = rd;
    addr     = a;
    wr_data  = d;
    if (!wr) m_rd = rb;
    sb_q.push_back(m_rd);
    for (int c = 1; c <= LEN; c++) begin
      @(negedge clk);
      start_wr = 1'b0;
      start_rd = 1'b0;
      if (c == pulse_c) start_rd = 1'b1;
      ad_in = (c > 4 * T && c <= 5 * T) ? rb : ~rb;
      tr_cs[c]   = cs_n;
      tr_adn[c]  = ad_n;
      tr_wr[c]   = wr_n;
      tr_rd[c]   = rd_n;
      tr_oe[c]   = ad_oe;
      tr_busy[c] = busy;
      tr_done[c] = done;
      tr_out[c]  = ad_out;
      ph  = (c - 1) / T;
      exp = {!(ph <= 5), !(ph <= 2), !(ph == 1 || (ph == 4 && wr)),
             !(ph == 4 && !wr), (ph <= 2) || (ph >= 3 && ph <= 5 && wr),
             ph <= 6, ph == 7};
      got = {cs_n, ad_n, wr_n, rd_n, ad_oe, busy, done};
      if ((got !== exp) || (ph <= 2 && ad_out !== a) ||
          (ph >= 3 && ph <= 5 && wr && ad_out !== d)) begin
        if (errs == 0) begin
          bad_c   = c;
          bad_got = got;
          bad_exp = exp;
        end
        errs = errs + 1;
      end
    end
    n_total = n_total + 1;
    if (errs == 0) n_pass = n_pass + 1;
    else $display("FAIL txn_pattern addr=%h: %0d bad cycles, first cycle %0d pins got %b expected %b",
                  a, errs, bad_c, bad_got, bad_exp);
    exp_rd  = sb_q.pop_front();
    n_total = n_total + 1;
    if (rd_data === exp_rd) n_pass = n_pass + 1;
    else $display("FAIL rd_data addr=%h: got %h expected %h", a, rd_data, exp_rd);
  endtask

  task automatic check_reset_values(input string name);
    n_total = n_total + 1;
    if ({cs_n, ad_n, wr_n, rd_n, ad_oe, busy, done} === 7'b1111000) n_pass = n_pass + 1;
    else $display("FAIL %s_ctrl: got %b expected 1111000", name,
                  {cs_n, ad_n, wr_n, rd_n, ad_oe, busy, done});
    n_total = n_total + 1;
    if ({ad_out, rd_data} === 16'h0000) n_pass = n_pass + 1;
    else $display("FAIL %s_data: ad_out=%h rd_data=%h expected 00 00", name, ad_out, rd_data);
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    start_wr = 1'b0;
    start_rd = 1'b0;
    addr     = 8'h00;
    wr_data  = 8'h00;
    ad_in    = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("post_reset_idle");
    #1 mon_en = 1'b1;
  endtask

  task automatic test_write();
    int cs_low;
    int wr_bad;
    int done_bad;
    drive_txn(1'b0, 1'b1, 1'b0, 8'h21, 8'h45, 8'h00, 0);
    cs_low   = 0;
    wr_bad   = 0;
    done_bad = 0;
    for (int c = 1; c <= LEN; c++) begin
      if (!tr_cs[c]) cs_low = cs_low + 1;
      if (tr_wr[c] !== !((c >= 5 && c <= 8) || (c >= 17 && c <= 20))) wr_bad = wr_bad + 1;
      if (tr_done[c] !== (c == 29)) done_bad = done_bad + 1;
    end
    n_total = n_total + 1;
    if (cs_low == 24) n_pass = n_pass + 1;
    else $display("FAIL write_cs_low_cycles: got %0d expected 24", cs_low);
    n_total = n_total + 1;
    if (wr_bad == 0 && tr_out[6] === 8'h21 && tr_out[18] === 8'h45) n_pass = n_pass + 1;
    else $display("FAIL write_strobe_data: %0d bad wr_n cycles, ad_out %h/%h expected 21/45",
                  wr_bad, tr_out[6], tr_out[18]);
    n_total = n_total + 1;
    if (done_bad == 0) n_pass = n_pass + 1;
    else $display("FAIL write_done_cycle: %0d cycles with wrong done, expected only cycle 29", done_bad);
  endtask

  task automatic test_read();
    int rd_low;
    int oe_bad;
    drive_txn(1'b0, 1'b0, 1'b1, 8'h41, 8'h00, 8'h37, 0);
    rd_low = 0;
    oe_bad = 0;
    for (int c = 1; c <= LEN; c++) begin
      if (!tr_rd[c]) rd_low = rd_low + 1;
      if (c >= 13 && tr_oe[c] !== 1'b0) oe_bad = oe_bad + 1;
    end
    n_total = n_total + 1;
    if (rd_low == 4 && tr_rd[17] === 1'b0 && tr_rd[20] === 1'b0) n_pass = n_pass + 1;
    else $display("FAIL read_rd_strobe: %0d low cycles, expected 4 at cycles 17-20", rd_low);
    n_total = n_total + 1;
    if (oe_bad == 0) n_pass = n_pass + 1;
    else $display("FAIL read_data_phase_oe: %0d cycles with ad_oe high, expected 0", oe_bad);
  endtask

  task automatic test_both_starts();
    int rd_low;
    drive_txn(1'b0, 1'b1, 1'b1, 8'hF1, 8'h08, 8'hE6, 0);
    rd_low = 0;
    for (int c = 1; c <= LEN; c++) if (!tr_rd[c]) rd_low = rd_low + 1;
    n_total = n_total + 1;
    if (rd_low == 0) n_pass = n_pass + 1;
    else $display("FAIL both_starts_rd_n: %0d low cycles, expected 0", rd_low);
  endtask

  task automatic test_ignore_then_back_to_back();
    drive_txn(1'b0, 1'b0, 1'b1, 8'h33, 8'h00, 8'hC4, 10);
    drive_txn(1'b1, 1'b1, 1'b0, 8'h5E, 8'hA7, 8'h00, 0);
    n_total = n_total + 1;
    if (tr_busy[1] === 1'b1 && tr_cs[1] === 1'b0) n_pass = n_pass + 1;
    else $display("FAIL back_to_back_busy: busy=%b cs_n=%b in first cycle expected 1 0",
                  tr_busy[1], tr_cs[1]);
  endtask

  task automatic test_reset_mid();
    int bad;
    @(negedge clk);
    start_wr = 1'b1;
    addr     = 8'h6C;
    wr_data  = 8'h19;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      start_wr = 1'b0;
    end
    n_total = n_total + 1;
    if (wr_n === 1'b0) n_pass = n_pass + 1;
    else $display("FAIL reset_mid_in_d_stb: wr_n=%b expected 0", wr_n);
    #1 mon_en = 1'b0;
    #1 reset  = 1'b1;
    #1 check_reset_values("reset_async");
    m_rd = 8'h00;
    @(negedge clk);
    #1 reset = 1'b0;
    bad = 0;
    repeat (LEN) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) bad = bad + 1;
    end
    n_total = n_total + 1;
    if (bad == 0) n_pass = n_pass + 1;
    else $display("FAIL reset_mid_no_done: %0d cycles with done or busy high, expected 0", bad);
    #1 mon_en = 1'b1;
    drive_txn(1'b0, 1'b1, 1'b0, 8'h7A, 8'h3D, 8'h00, 0);
  endtask

  task automatic test_random_back_to_back();
    logic wr;
    logic rd;
    for (int i = 0; i < 10; i++) begin
      wr = 1'($urandom_range(0, 1));
      rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      drive_txn(i > 0, wr, rd, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                8'($urandom_range(0, 255)), 0);
    end
    @(negedge clk);
    n_total = n_total + 1;
    if (viol == 0) n_pass = n_pass + 1;
    else $display("FAIL bus_invariants: %0d violations, expected 0", viol);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_both_starts();
    test_ignore_then_back_to_back();
    test_reset_mid();
    test_random_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rtc_bus_cycle.md
# rtc_bus_cycle

Bus-cycle generator sitting directly downstream of the RTC address/data byte selector. Takes the selected register address byte (and write data, when writing) and executes one complete multiplexed-bus transaction on the RTC chip pins: address phase (A/D low, WR strobe), then data phase (write with WR strobe, or read with RD strobe and capture). The sequencer FSM upstream issues one request at a time and waits for `done`.

## Interface
- `T_PHASE`, default 10: cycles spent in each non-idle state; legal range 2..255; 10 gives 100 ns per phase at 100 MHz.

- `clk`  in  1  system clock; all logic rising-edge.
- `reset`  in  1  asynchronous, active-high; returns the block to IDLE.
- `start_wr`  in  1  request a write transaction; sampled only in IDLE.
- `start_rd`  in  1  request a read transaction; sampled only in IDLE.
- `addr`  in  8  register address byte from the address/data selector; latched at accept.
- `wr_data`  in  8  write data byte; latched at accept.
- `ad_in`  in  8  RTC AD bus input (pad input side).
- `ad_out`  out  8  RTC AD bus output value.
- `ad_oe`  out  1  1 = block drives AD bus; 0 = tri-state.
- `cs_n`  out  1  RTC chip select, active-low.
- `ad_n`  out  1  address/data select: 0 = address phase, 1 = data phase.
- `wr_n`  out  1  write strobe, active-low.
- `rd_n`  out  1  read strobe, active-low.
- `rd_data`  out  8  byte captured in last read; held until the next read completes.
- `busy`  out  1  high from accept until the `done` cycle (exclusive).
- `done`  out  1  one-cycle pulse at transaction end.

## Operation
- States: IDLE, A_SET, A_STB, A_HLD, D_SET, D_STB, D_HLD, GAP. Each non-IDLE state lasts exactly `T_PHASE` cycles (down-counter loaded with `T_PHASE-1` on state entry, advance at zero). Sequence is fixed, no branching except read/write output values.
- Accept: in IDLE, `start_wr` or `start_rd` high → latch `addr`, `wr_data`, op (write wins if both high) → A_SET. Starts outside IDLE are ignored, not queued.
- Output values per state (all outputs registered):
  - IDLE: cs_n=1, ad_n=1, wr_n=1, rd_n=1, ad_oe=0, busy=0.
  - A_SET: cs_n=0, ad_n=0, ad_oe=1, ad_out=latched addr.
  - A_STB: as A_SET plus wr_n=0 (address always latched with WR, for both ops).
  - A_HLD: as A_SET, wr_n=1.
  - D_SET: cs_n=0, ad_n=1; write: ad_oe=1, ad_out=wr_data; read: ad_oe=0.
  - D_STB: as D_SET plus wr_n=0 (write) or rd_n=0 (read).
  - D_HLD: as D_SET, strobes high.
  - GAP: cs_n=1, ad_n=1, ad_oe=0, strobes high; busy still 1.
- Read capture: `rd_data <= ad_in` on the clock edge ending the last D_STB cycle (rd_n still low). Writes never modify `rd_data`.
- wr_n and rd_n are never low simultaneously; a strobe is never low while cs_n=1; ad_oe and ad_out change only when both strobes are high.

## Timing
- Reset values: cs_n=1, ad_n=1, wr_n=1, rd_n=1, ad_oe=0, ad_out=8'h00, rd_data=8'h00, busy=0, done=0, state IDLE.
- Start sampled at edge k → A_SET outputs and busy=1 visible after edge k.
- Transaction length: 7·`T_PHASE` cycles with busy=1, then one cycle with done=1, busy=0 (state IDLE). `rd_data` valid in the done cycle.
- Start high in the done cycle is accepted (back-to-back, zero extra idle); this gives minimum repetition period 7·`T_PHASE`+1.
- Strobe low width = `T_PHASE` cycles; address/data setup and hold to strobe = `T_PHASE` cycles each.
- Reset mid-transaction: immediate return to reset values, no done pulse, rd_data unchanged only in value it had (reset clears it to 00).

## Test plan
- `T_PHASE`=4, start_wr, addr=21, wr_data=45 → cs_n low 24 cycles; ad_n=0/ad_out=21 12 cycles with wr_n low cycles 5–8; ad_out=45 with wr_n low cycles 17–20; done at cycle 29.
- `T_PHASE`=4, start_rd, addr=41, ad_in=37 during D_STB → rd_n low 4 cycles, ad_oe=0 in data phase, rd_data=37 in done cycle; wr_n low only in address phase.
- start_wr and start_rd together (addr=F1, wr_data=08) → write cycle executed, rd_n never low, rd_data unchanged.
- start_rd pulsed while busy, then start_wr asserted in done cycle → mid-busy request ignored; write accepted immediately, busy re-asserted next cycle.
- reset asserted during D_STB of a write → all outputs at reset values asynchronously, no done; subsequent start_wr completes normally.
- Random back-to-back reads/writes with scoreboard → strobe exclusivity, cs_n/strobe ordering, and captured bytes match model.
